// File: rtl/pipeline_wb_if.sv
// Purpose: MEM -> WB handshake and payload bundle for pipeline_wb_stage.
// Signals:
//   in_valid / in_ready : valid/ready handshake (ready driven by the WB stage)
//   flush               : squash the instruction presented this cycle
//   in_src              : NSRC packed write-back sources, source k at [k*XLEN +: XLEN]
//   in_sel              : source select
//   in_we, in_rd        : register write enable and destination
//   in_funct3           : load type
//   in_addr_lo          : low address bits of the load
//   in_dbg              : debug bundle carried alongside the instruction
// Modports: master (MEM stage side), slave (WB stage side).
interface pipeline_wb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned DBG_W = 64
);
    localparam int unsigned SELW = $clog2(NSRC);
    localparam int unsigned ALW  = $clog2(XLEN / 8);

    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [NSRC*XLEN-1:0] in_src;
    logic [SELW-1:0]      in_sel;
    logic                 in_we;
    logic [4:0]           in_rd;
    logic [2:0]           in_funct3;
    logic [ALW-1:0]       in_addr_lo;
    logic [DBG_W-1:0]     in_dbg;

    modport master (
        output in_valid, flush, in_src, in_sel, in_we, in_rd, in_funct3, in_addr_lo, in_dbg,
        input  in_ready
    );

    modport slave (
        input  in_valid, flush, in_src, in_sel, in_we, in_rd, in_funct3, in_addr_lo, in_dbg,
        output in_ready
    );
endinterface

// File: rtl/pipeline_wb_stage.sv
// Purpose: pipelined CPU write-back stage. Holds one MEM/WB instruction, selects
// the write-back value, waits for variable-latency load data and drives the
// register-file write port, forwarding, debug and retire-count outputs.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wb (slave)          : MEM-side handshake and payload (see pipeline_wb_if)
//   dmem_rvalid/rdata   : load data return
//   rf_we/rf_rd/rf_wdata: register-file write port
//   fwd_valid           : forwarding value valid (same as rf_we)
//   busy                : waiting for load data
//   retire_cnt          : completed instruction counter (wraps)
//   out_dbg             : registered debug bundle
module pipeline_wb_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned MEM_IDX = 1,
    parameter int unsigned DBG_W   = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipeline_wb_if.slave       wb,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               rf_we,
    output logic [4:0]         rf_rd,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               fwd_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [DBG_W-1:0]   out_dbg
);
    localparam int unsigned SELW = $clog2(NSRC);
    localparam int unsigned ALW  = $clog2(XLEN / 8);
    localparam int unsigned SHW  = ALW + 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NSRC*XLEN-1:0] src_q, src_d;
    logic [SELW-1:0]      sel_q, sel_d;
    logic                 we_q, we_d;
    logic [4:0]           rd_q, rd_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [ALW-1:0]       addr_lo_q, addr_lo_d;
    logic [DBG_W-1:0]     dbg_q, dbg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 done_c;
    logic                 ready_c;
    logic                 capture_c;
    logic [XLEN-1:0]      src_val_c;
    logic [SHW-1:0]       shamt_c;
    logic [XLEN-1:0]      shifted_c;
    logic [XLEN-1:0]      load_c;

    // State and held-payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            src_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            dbg_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            dbg_q     <= dbg_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state, capture and retire counting
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        dbg_d     = dbg_q;
        cnt_d     = cnt_q;

        done_c    = (state_q == ST_FULL) || ((state_q == ST_WAIT) && dmem_rvalid);
        // Ready in the load completion cycle lets the next instruction slip in without a bubble
        ready_c   = (state_q != ST_WAIT) || dmem_rvalid;
        capture_c = wb.in_valid && ready_c && !wb.flush;

        if (done_c) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_EMPTY;
        end

        if (capture_c) begin
            src_d     = wb.in_src;
            sel_d     = wb.in_sel;
            we_d      = wb.in_we;
            rd_d      = wb.in_rd;
            funct3_d  = wb.in_funct3;
            addr_lo_d = wb.in_addr_lo;
            dbg_d     = wb.in_dbg;
            state_d   = (wb.in_sel == SELW'(MEM_IDX)) ? ST_WAIT : ST_FULL;
        end
    end

    // Held-source mux; a select beyond NSRC-1 matches nothing and yields 0
    always_comb begin
        src_val_c = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (sel_q == SELW'(k)) begin
                src_val_c = src_q[k*XLEN +: XLEN];
            end
        end
    end

    // Load alignment and extension
    always_comb begin
        shamt_c   = {addr_lo_q, 3'b000};
        shifted_c = dmem_rdata >> shamt_c;
        case (funct3_q)
            3'b000:  load_c = XLEN'($signed(shifted_c[7:0]));
            3'b100:  load_c = XLEN'(shifted_c[7:0]);
            3'b001:  load_c = XLEN'($signed(shifted_c[15:0]));
            3'b101:  load_c = XLEN'(shifted_c[15:0]);
            3'b010:  load_c = XLEN'($signed(shifted_c[31:0]));
            3'b110:  load_c = (XLEN == 64) ? XLEN'(shifted_c[31:0]) : dmem_rdata;
            3'b011:  load_c = (XLEN == 64) ? shifted_c : dmem_rdata;
            default: load_c = dmem_rdata;
        endcase
    end

    // Memory data only reaches the write port while a load is pending
    assign rf_wdata    = (state_q == ST_WAIT)         ? load_c :
                         (sel_q == SELW'(MEM_IDX))    ? '0     : src_val_c;
    assign rf_we       = done_c && we_q && (rd_q != 5'd0);
    assign rf_rd       = rd_q;
    assign fwd_valid   = rf_we;
    assign busy        = (state_q == ST_WAIT);
    assign retire_cnt  = cnt_q;
    assign out_dbg     = dbg_q;
    assign wb.in_ready = ready_c;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Purpose: self-checking bench for pipeline_wb_stage (XLEN=32, NSRC=4, MEM_IDX=1).
// A second instance with a 4-bit retire counter shares the stimulus to check wrap.
module tb_pipeline_wb_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NSRC  = 4;
    localparam int unsigned DBG_W = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, in_we;
    logic [1:0]  in_sel, in_addr_lo;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [63:0] in_dbg;
    logic [31:0] src [4];
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        rf_we, fwd_valid, busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata, retire_cnt;
    logic [63:0] out_dbg;
    logic        rf_we4, fwd_valid4, busy4;
    logic [4:0]  rf_rd4;
    logic [31:0] rf_wdata4;
    logic [3:0]  retire_cnt4;
    logic [63:0] out_dbg4;

    int n_vec  = 0;
    int n_fail = 0;

    pipeline_wb_if #(.XLEN(XLEN), .NSRC(NSRC), .DBG_W(DBG_W)) wb  ();
    pipeline_wb_if #(.XLEN(XLEN), .NSRC(NSRC), .DBG_W(DBG_W)) wb4 ();

    assign wb.in_valid    = in_valid;
    assign wb.flush       = flush;
    assign wb.in_src      = {src[3], src[2], src[1], src[0]};
    assign wb.in_sel      = in_sel;
    assign wb.in_we       = in_we;
    assign wb.in_rd       = in_rd;
    assign wb.in_funct3   = in_funct3;
    assign wb.in_addr_lo  = in_addr_lo;
    assign wb.in_dbg      = in_dbg;
    assign wb4.in_valid   = in_valid;
    assign wb4.flush      = flush;
    assign wb4.in_src     = {src[3], src[2], src[1], src[0]};
    assign wb4.in_sel     = in_sel;
    assign wb4.in_we      = in_we;
    assign wb4.in_rd      = in_rd;
    assign wb4.in_funct3  = in_funct3;
    assign wb4.in_addr_lo = in_addr_lo;
    assign wb4.in_dbg     = in_dbg;

    pipeline_wb_stage #(.XLEN(32), .NSRC(4), .MEM_IDX(1), .DBG_W(64), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .wb(wb), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
        .busy(busy), .retire_cnt(retire_cnt), .out_dbg(out_dbg)
    );

    pipeline_wb_stage #(.XLEN(32), .NSRC(4), .MEM_IDX(1), .DBG_W(64), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wb(wb4), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we4), .rf_rd(rf_rd4), .rf_wdata(rf_wdata4), .fwd_valid(fwd_valid4),
        .busy(busy4), .retire_cnt(retire_cnt4), .out_dbg(out_dbg4)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Load result from raw memory word using plain arithmetic on byte/halfword values
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] raw);
        longint unsigned sh, b, h;
        sh = 64'(raw) >> (8 * a);
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            3'b000:  return 32'((b >= 128) ? b + 64'h0000_0000_FFFF_FF00 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'((h >= 32768) ? h + 64'h0000_0000_FFFF_0000 : h);
            3'b101:  return 32'(h);
            3'b010:  return 32'(sh);
            default: return raw;
        endcase
    endfunction

    logic        m_has, m_load, m_we;
    logic [31:0] m_src [4];
    logic [1:0]  m_sel, m_addr;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [63:0] m_dbg;
    int unsigned m_cnt;

    logic        e_done, e_ready, e_busy, e_we;
    logic [31:0] e_wdata;

    always_comb begin
        e_done  = m_has && (!m_load || dmem_rvalid);
        e_ready = !(m_has && m_load) || dmem_rvalid;
        e_busy  = m_has && m_load;
        e_we    = e_done && m_we && (m_rd != 5'd0);
        e_wdata = m_load ? load_val(m_f3, m_addr, dmem_rdata)
                         : ((int'(m_sel) < int'(NSRC)) ? m_src[m_sel] : 32'd0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has  <= 1'b0;
            m_load <= 1'b0;
            m_we   <= 1'b0;
            m_sel  <= '0;
            m_addr <= '0;
            m_rd   <= '0;
            m_f3   <= '0;
            m_dbg  <= '0;
            m_cnt  <= 0;
            for (int k = 0; k < 4; k++) m_src[k] <= '0;
        end else begin
            if (e_done) begin
                m_cnt <= m_cnt + 1;
                m_has <= 1'b0;
            end
            if (in_valid && e_ready && !flush) begin
                m_has  <= 1'b1;
                m_load <= (in_sel == 2'd1);
                m_we   <= in_we;
                m_sel  <= in_sel;
                m_addr <= in_addr_lo;
                m_rd   <= in_rd;
                m_f3   <= in_funct3;
                m_dbg  <= in_dbg;
                for (int k = 0; k < 4; k++) m_src[k] <= src[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        chk("ready",   64'(wb.in_ready),  64'(e_ready));
        chk("busy",    64'(busy),         64'(e_busy));
        chk("rf_we",   64'(rf_we),        64'(e_we));
        chk("fwd",     64'(fwd_valid),    64'(e_we));
        chk("retire",  64'(retire_cnt),   64'(m_cnt));
        chk("dbg",     out_dbg,           m_dbg);
        chk("ready4",  64'(wb4.in_ready), 64'(e_ready));
        chk("rf_we4",  64'(rf_we4),       64'(e_we));
        chk("retire4", 64'(retire_cnt4),  64'(m_cnt % 16));
        if (e_we) begin
            chk("rf_rd",    64'(rf_rd),    64'(m_rd));
            chk("rf_wdata", 64'(rf_wdata), 64'(e_wdata));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid    = 1'b0;
        flush       = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] addr);
        in_valid   = 1'b1;
        flush      = 1'b0;
        in_sel     = sel;
        in_we      = we;
        in_rd      = rd;
        in_funct3  = f3;
        in_addr_lo = addr;
        in_dbg     = 64'hDB60_0000_0000_0000 | 64'(rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
        $fatal(1);
    end

    initial begin
        idle();
        in_sel = '0; in_we = 1'b0; in_rd = '0; in_funct3 = '0; in_addr_lo = '0; in_dbg = '0;
        src[0] = 32'h0000_1234; src[1] = 32'h0000_0BAD; src[2] = 32'h0000_0055; src[3] = 32'h0000_0104;
        dmem_rdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_rf_we",  64'(rf_we),       64'd0);
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_ready",  64'(wb.in_ready), 64'd1);
        chk("rst_retire", 64'(retire_cnt),  64'd0);
        chk("rst_dbg",    out_dbg,          64'd0);
        #2 rst_n = 1'b1;
        tick();

        // ALU source 0
        issue(2'd0, 1'b1, 5'd5, 3'b000, 2'd0);
        tick(); idle();
        @(negedge clk);
        chk("alu_we",      64'(rf_we),    64'd1);
        chk("alu_rd",      64'(rf_rd),    64'd5);
        chk("alu_wdata",   64'(rf_wdata), 64'h1234);
        chk("model_alu",   64'(e_wdata),  64'h1234);
        chk("alu_dbg",     out_dbg,       64'hDB60_0000_0000_0005);
        tick();
        @(negedge clk);
        chk("alu_retire",  64'(retire_cnt), 64'd1);

        // LB with 3 extra cycles of memory latency
        dmem_rdata = 32'h80FF_0000;
        issue(2'd1, 1'b1, 5'd6, 3'b000, 2'd3);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_busy",  64'(busy),        64'd1);
            chk("lb_ready", 64'(wb.in_ready), 64'd0);
            chk("lb_nowe",  64'(rf_we),       64'd0);
            tick();
        end
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("lb_we",       64'(rf_we),    64'd1);
        chk("lb_wdata",    64'(rf_wdata), 64'hFFFF_FF80);
        chk("model_lb",    64'(e_wdata),  64'hFFFF_FF80);
        tick(); idle();
        @(negedge clk);
        chk("lb_after",    64'(rf_we),    64'd0);

        // LBU, same data, immediate return
        issue(2'd1, 1'b1, 5'd7, 3'b100, 2'd3);
        tick(); idle();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("lbu_wdata",   64'(rf_wdata), 64'h80);
        chk("model_lbu",   64'(e_wdata),  64'h80);
        tick(); idle();

        // Load completes while next ALU op is captured
        dmem_rdata = 32'hDEAD_BEEF;
        issue(2'd1, 1'b1, 5'd8, 3'b010, 2'd0);
        tick();
        issue(2'd2, 1'b1, 5'd9, 3'b000, 2'd0);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("b2b_ld_wdata", 64'(rf_wdata),    64'hDEAD_BEEF);
        chk("b2b_ready",    64'(wb.in_ready), 64'd1);
        chk("b2b_cnt0",     64'(retire_cnt),  64'd3);
        tick(); idle();
        @(negedge clk);
        chk("b2b_alu_we",   64'(rf_we),    64'd1);
        chk("b2b_alu_rd",   64'(rf_rd),    64'd9);
        chk("b2b_alu_data", 64'(rf_wdata), 64'h55);
        tick();
        @(negedge clk);
        chk("b2b_cnt2",     64'(retire_cnt), 64'd5);

        // Flush of the incoming instruction
        issue(2'd0, 1'b1, 5'd10, 3'b000, 2'd0);
        flush = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("flush_we",     64'(rf_we), 64'd0);
        chk("flush_busy",   64'(busy),  64'd0);

        // Flush while a load is held: the load still completes
        dmem_rdata = 32'h8001_0000;
        issue(2'd1, 1'b1, 5'd11, 3'b001, 2'd2);
        tick();
        issue(2'd0, 1'b1, 5'd12, 3'b000, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("fw_busy",      64'(busy), 64'd1);
        tick();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("fw_we",        64'(rf_we),    64'd1);
        chk("fw_wdata",     64'(rf_wdata), 64'hFFFF_8001);
        chk("model_lh",     64'(e_wdata),  64'hFFFF_8001);
        tick(); idle();
        @(negedge clk);
        chk("fw_nocap",     64'(rf_we),      64'd0);
        chk("fw_retire",    64'(retire_cnt), 64'd6);

        // rd=0 retires without writing
        issue(2'd0, 1'b1, 5'd0, 3'b000, 2'd0);
        tick(); idle();
        @(negedge clk);
        chk("rd0_we",       64'(rf_we), 64'd0);
        tick();
        @(negedge clk);
        chk("rd0_retire",   64'(retire_cnt), 64'd7);

        // PC+4 on source 3
        issue(2'd3, 1'b1, 5'd12, 3'b000, 2'd0);
        tick(); idle();
        @(negedge clk);
        chk("sel3_wdata",   64'(rf_wdata), 64'h104);
        tick();

        // Undefined load code passes the raw word
        dmem_rdata = 32'h1234_5678;
        issue(2'd1, 1'b1, 5'd13, 3'b111, 2'd1);
        tick(); idle();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("raw_wdata",    64'(rf_wdata), 64'h1234_5678);
        tick(); idle();

        // LHU upper halfword
        dmem_rdata = 32'h8001_0000;
        issue(2'd1, 1'b1, 5'd14, 3'b101, 2'd2);
        tick(); idle();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("lhu_wdata",    64'(rf_wdata), 64'h8001);
        chk("model_lhu",    64'(e_wdata),  64'h8001);
        tick(); idle();

        // Asynchronous reset while a load is pending
        issue(2'd1, 1'b1, 5'd15, 3'b000, 2'd0);
        tick(); idle();
        @(negedge clk);
        chk("ar_busy_pre",  64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy",      64'(busy),        64'd0);
        chk("ar_retire",    64'(retire_cnt),  64'd0);
        chk("ar_ready",     64'(wb.in_ready), 64'd1);
        #1 rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        @(negedge clk);
        chk("ar_ignore_we", 64'(rf_we), 64'd0);
        tick(); idle();
        @(negedge clk);
        chk("ar_retire2",   64'(retire_cnt), 64'd0);

        // 17 back-to-back completions wrap a 4-bit counter to 1
        issue(2'd0, 1'b0, 5'd1, 3'b000, 2'd0);
        repeat (17) tick();
        idle();
        tick();
        @(negedge clk);
        chk("wrap_cnt4",    64'(retire_cnt4), 64'd1);
        chk("wrap_cnt32",   64'(retire_cnt),  64'd17);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
